// File: rtl/shiftreg_pkg.sv
// Shared constants for the LED pattern shifter: mode encodings and ping-pong direction.
package shiftreg_pkg;

  localparam logic [1:0] MODE_ROL   = 2'b00;
  localparam logic [1:0] MODE_ROR   = 2'b01;
  localparam logic [1:0] MODE_PONG  = 2'b10;
  localparam logic [1:0] MODE_FLASH = 2'b11;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic {
    ST_UP   = DIR_UP,
    ST_DOWN = DIR_DOWN
  } pong_state_e;

endpackage

// File: rtl/shiftreg_pattern_rate_tick.sv
// Rate generator: selectable-limit counter that pulses tick once per lim+1 enabled cycles.
module rate_tick #(
  parameter int                    NB_COUNTER = 8,
  parameter logic [NB_COUNTER-1:0] R0         = 8'd15,
  parameter logic [NB_COUNTER-1:0] R1         = 8'd31,
  parameter logic [NB_COUNTER-1:0] R2         = 8'd63,
  parameter logic [NB_COUNTER-1:0] R3         = 8'd127
) (
  input  logic       clock,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [1:0] i_rate,
  output logic       o_tick
);

  logic [NB_COUNTER-1:0] cnt_q, cnt_d;
  logic [NB_COUNTER-1:0] lim;

  always_comb begin
    lim = R0;
    case (i_rate)
      2'b00:   lim = R0;
      2'b01:   lim = R1;
      2'b10:   lim = R2;
      default: lim = R3;
    endcase
  end

  // ">=" lets a lowered limit fire immediately instead of wrapping the counter.
  assign o_tick = i_enable && (cnt_q >= lim);

  always_comb begin
    cnt_d = cnt_q;
    if (o_tick)
      cnt_d = '0;
    else if (i_enable)
      cnt_d = cnt_q + NB_COUNTER'(1);
  end

  always_ff @(posedge clock) begin
    if (!i_reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/shiftreg_pattern.sv
// LED pattern shifter: rotate left/right, ping-pong and flash modes advanced by a selectable rate tick.
module shiftreg_pattern
  import shiftreg_pkg::*;
#(
  parameter int                    NB_LEDS    = 4,
  parameter int                    NB_COUNTER = 8,
  parameter logic [NB_COUNTER-1:0] R0         = 8'd15,
  parameter logic [NB_COUNTER-1:0] R1         = 8'd31,
  parameter logic [NB_COUNTER-1:0] R2         = 8'd63,
  parameter logic [NB_COUNTER-1:0] R3         = 8'd127
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [2:0]         i_sw,
  input  logic [1:0]         i_mode,
  output logic [NB_LEDS-1:0] o_led,
  output logic               o_valid,
  output logic               o_dir
);

  logic               tick;
  logic               flash_exit;
  logic [NB_LEDS-1:0] led_q, led_d;
  logic               valid_q, valid_d;
  logic               phase_q, phase_d;
  logic               prev_flash_q, prev_flash_d;
  pong_state_e        state_q, state_d;

  rate_tick #(
    .NB_COUNTER (NB_COUNTER),
    .R0         (R0),
    .R1         (R1),
    .R2         (R2),
    .R3         (R3)
  ) u_rate_tick (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_enable (i_sw[0]),
    .i_rate   (i_sw[2:1]),
    .o_tick   (tick)
  );

  // The first tick after flash reloads a clean one-hot pattern instead of updating it.
  assign flash_exit = (i_mode != MODE_FLASH) && prev_flash_q;

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      state_q      <= ST_UP;
      led_q        <= NB_LEDS'(1);
      valid_q      <= 1'b0;
      phase_q      <= 1'b0;
      prev_flash_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      led_q        <= led_d;
      valid_q      <= valid_d;
      phase_q      <= phase_d;
      prev_flash_q <= prev_flash_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      if (flash_exit)
        state_d = ST_UP;
      else if (i_mode == MODE_PONG) begin
        case (state_q)
          ST_UP:   if (led_q[NB_LEDS-1]) state_d = ST_DOWN;
          ST_DOWN: if (led_q[0])         state_d = ST_UP;
          default: state_d = ST_UP;
        endcase
      end
    end
  end

  always_comb begin
    led_d        = led_q;
    phase_d      = phase_q;
    prev_flash_d = prev_flash_q;
    valid_d      = tick;
    if (tick) begin
      if (flash_exit) begin
        led_d        = NB_LEDS'(1);
        phase_d      = 1'b0;
        prev_flash_d = 1'b0;
      end else begin
        case (i_mode)
          MODE_ROL:  led_d = {led_q[NB_LEDS-2:0], led_q[NB_LEDS-1]};
          MODE_ROR:  led_d = {led_q[0], led_q[NB_LEDS-1:1]};
          MODE_PONG: led_d = (state_d == ST_DOWN) ? {1'b0, led_q[NB_LEDS-1:1]}
                                                  : {led_q[NB_LEDS-2:0], 1'b0};
          default: begin
            led_d        = phase_q ? '0 : '1;
            phase_d      = ~phase_q;
            prev_flash_d = 1'b1;
          end
        endcase
      end
    end
  end

  assign o_led   = led_q;
  assign o_valid = valid_q;
  assign o_dir   = (state_q == ST_DOWN);

endmodule

// File: tb/tb_shiftreg_pattern.sv
// Directed self-checking bench for shiftreg_pattern with default parameters (4 LEDs, R0=15 .. R3=127).
module tb_shiftreg_pattern;

  logic       clock;
  logic       i_reset;
  logic [2:0] i_sw;
  logic [1:0] i_mode;
  logic [3:0] o_led;
  logic       o_valid;
  logic       o_dir;

  int tests_run;
  int tests_failed;

  shiftreg_pattern dut (
    .clock   (clock),
    .i_reset (i_reset),
    .i_sw    (i_sw),
    .i_mode  (i_mode),
    .o_led   (o_led),
    .o_valid (o_valid),
    .o_dir   (o_dir)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle before sampling or driving.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Two reset edges, then release; the next step is the first edge out of reset.
  task automatic do_reset(input logic [2:0] sw, input logic [1:0] mode);
    i_reset = 1'b0;
    i_sw    = sw;
    i_mode  = mode;
    step();
    step();
    i_reset = 1'b1;
  endtask

  // Steps until o_valid is seen; cycles = edges taken, capped at 300.
  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!o_valid && cycles < 300);
  endtask

  task automatic test_reset();
    int cyc;
    logic [3:0] exp_led [3] = '{4'b0010, 4'b0100, 4'b1000};
    i_reset = 1'b0;
    i_sw    = 3'b001;
    i_mode  = 2'b00;
    step();
    step();
    tests_run++;
    if (o_led !== 4'b0001 || o_valid !== 1'b0 || o_dir !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: led=%b valid=%b dir=%b, expected led=0001 valid=0 dir=0", o_led, o_valid, o_dir);
    end
    i_reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_tick(cyc);
      tests_run++;
      if (cyc !== 16 || o_led !== exp_led[k]) begin
        tests_failed++;
        $display("[TB] FAIL rate0_pulse%0d: cycles=%0d led=%b, expected cycles=16 led=%b", k, cyc, o_led, exp_led[k]);
      end
    end
  endtask

  task automatic test_rate_drop();
    int cyc;
    do_reset(3'b111, 2'b00);
    for (int k = 0; k < 40; k++) step();
    tests_run++;
    if (o_valid !== 1'b0 || o_led !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL rate3_midcount: valid=%b led=%b, expected valid=0 led=0001", o_valid, o_led);
    end
    i_sw = 3'b001;
    step();
    tests_run++;
    if (o_valid !== 1'b1 || o_led !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL rate_drop_fire: valid=%b led=%b, expected valid=1 led=0010", o_valid, o_led);
    end
    wait_tick(cyc);
    tests_run++;
    if (cyc !== 16 || o_led !== 4'b0100) begin
      tests_failed++;
      $display("[TB] FAIL rate_drop_next: cycles=%0d led=%b, expected cycles=16 led=0100", cyc, o_led);
    end
  endtask

  task automatic test_rotate_right();
    int cyc;
    logic [3:0] exp_led [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    do_reset(3'b001, 2'b01);
    for (int k = 0; k < 4; k++) begin
      wait_tick(cyc);
      tests_run++;
      if (cyc !== 16 || o_led !== exp_led[k] || o_dir !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL ror_tick%0d: cycles=%0d led=%b dir=%b, expected cycles=16 led=%b dir=0", k, cyc, o_led, o_dir, exp_led[k]);
      end
    end
  endtask

  task automatic test_pingpong_flash();
    int cyc;
    logic [3:0] exp_led [10] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010,
                                 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};
    logic       exp_dir [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] flash_led [3] = '{4'b1111, 4'b0000, 4'b1111};
    do_reset(3'b001, 2'b10);
    for (int k = 0; k < 10; k++) begin
      wait_tick(cyc);
      tests_run++;
      if (cyc !== 16 || o_led !== exp_led[k] || o_dir !== exp_dir[k]) begin
        tests_failed++;
        $display("[TB] FAIL pong_tick%0d: cycles=%0d led=%b dir=%b, expected cycles=16 led=%b dir=%b", k, cyc, o_led, o_dir, exp_led[k], exp_dir[k]);
      end
    end
    i_mode = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_tick(cyc);
      tests_run++;
      if (cyc !== 16 || o_led !== flash_led[k] || o_dir !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL flash_tick%0d: cycles=%0d led=%b dir=%b, expected cycles=16 led=%b dir=1", k, cyc, o_led, o_dir, flash_led[k]);
      end
    end
    i_mode = 2'b00;
    wait_tick(cyc);
    tests_run++;
    if (o_led !== 4'b0001 || o_dir !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL flash_exit: led=%b dir=%b, expected led=0001 dir=0", o_led, o_dir);
    end
    wait_tick(cyc);
    tests_run++;
    if (cyc !== 16 || o_led !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL after_flash_rol: cycles=%0d led=%b, expected cycles=16 led=0010", cyc, o_led);
    end
  endtask

  task automatic test_enable_freeze();
    int cyc;
    int bad;
    do_reset(3'b001, 2'b00);
    for (int k = 0; k < 7; k++) step();
    i_sw = 3'b000;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (o_valid !== 1'b0 || o_led !== 4'b0001) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("[TB] FAIL freeze_hold: %0d of 50 cycles changed (led=%b valid=%b), expected led=0001 valid=0 throughout", bad, o_led, o_valid);
    end
    i_sw = 3'b001;
    wait_tick(cyc);
    tests_run++;
    if (cyc !== 9 || o_led !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL freeze_resume: cycles=%0d led=%b, expected cycles=9 led=0010", cyc, o_led);
    end
  endtask

  task automatic test_reset_midop();
    int cyc;
    do_reset(3'b001, 2'b10);
    for (int k = 0; k < 4; k++) wait_tick(cyc);
    tests_run++;
    if (o_led !== 4'b0100 || o_dir !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midop_setup: led=%b dir=%b, expected led=0100 dir=1", o_led, o_dir);
    end
    for (int k = 0; k < 5; k++) step();
    i_reset = 1'b0;
    step();
    tests_run++;
    if (o_led !== 4'b0001 || o_dir !== 1'b0 || o_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midop_reset: led=%b dir=%b valid=%b, expected led=0001 dir=0 valid=0", o_led, o_dir, o_valid);
    end
    i_reset = 1'b1;
    wait_tick(cyc);
    tests_run++;
    if (cyc !== 16 || o_led !== 4'b0010 || o_dir !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midop_restart: cycles=%0d led=%b dir=%b, expected cycles=16 led=0010 dir=0", cyc, o_led, o_dir);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    i_reset      = 1'b0;
    i_sw         = 3'b000;
    i_mode       = 2'b00;
    test_reset();
    test_rate_drop();
    test_rotate_right();
    test_pingpong_flash();
    test_enable_freeze();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
